// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared encodings and defaults for the instruction fetch unit
package instr_fetch_unit_pkg;

  localparam int ADDR_W_DEF  = 21;
  localparam int INSTR_W_DEF = 32;

  // Must match the control unit's pcControl outputs.
  typedef enum logic [2:0] {
    PC_SEQ = 3'd0,
    PC_JMP = 3'd1,
    PC_JE  = 3'd2,
    PC_JNE = 3'd3,
    PC_JB  = 3'd4,
    PC_JA  = 3'd5,
    PC_JBE = 3'd6,
    PC_JAE = 3'd7
  } pc_ctrl_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_FETCH  = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_UPDATE = 2'd2;
  localparam state_t ST_HALT   = 2'd3;

endpackage

// File: rtl/instr_fetch_unit_branch_resolve.sv
// rtl/instr_fetch_unit_branch_resolve.sv - combinational branch condition resolver
module instr_fetch_unit_branch_resolve
  import instr_fetch_unit_pkg::*;
(
  input  logic [2:0] pc_control,
  input  logic       zero_flag,
  input  logic       below_flag,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (pc_control)
      PC_SEQ:  taken = 1'b0;
      PC_JMP:  taken = 1'b1;
      PC_JE:   taken = zero_flag;
      PC_JNE:  taken = !zero_flag;
      PC_JB:   taken = below_flag;
      PC_JA:   taken = !below_flag && !zero_flag;
      PC_JBE:  taken = below_flag || zero_flag;
      PC_JAE:  taken = !below_flag;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch FSM; IFU_BRANCH_COUNT_EN adds a taken-branch counter
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INSTR_W  = INSTR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  input  logic [2:0]         pc_control,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               zero_flag,
  input  logic               below_flag,
  input  logic               halt,
  input  logic               exec_done,
`ifdef IFU_BRANCH_COUNT_EN
  output logic [15:0]        branch_count,
`endif
  output logic               halted
);

  state_t state;
  logic   active;
  logic   taken;

  instr_fetch_unit_branch_resolve u_branch_resolve (
    .pc_control (pc_control),
    .zero_flag  (zero_flag),
    .below_flag (below_flag),
    .taken      (taken)
  );

  // active keeps mem_req low in the first cycle after reset is sampled.
  assign mem_req  = (state == ST_FETCH) && active;
  assign mem_addr = pc;
  assign halted   = (state == ST_HALT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      active      <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (mem_req && mem_ready) begin
            instruction <= mem_data;
            instr_valid <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exec_done) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          instr_valid <= 1'b0;
          if (halt) begin
            state <= ST_HALT;
          end else begin
            pc    <= taken ? jump_target : pc + 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_HALT: instr_valid <= 1'b0;
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef IFU_BRANCH_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      branch_count <= '0;
    end else if (state == ST_UPDATE && !halt && taken && pc_control != PC_SEQ
                 && branch_count != 16'hFFFF) begin
      branch_count <= branch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [20:0] pc;
  logic [2:0]  pc_control = '0;
  logic [20:0] jump_target = '0;
  logic        zero_flag = 1'b0;
  logic        below_flag = 1'b0;
  logic        halt = 1'b0;
  logic        exec_done = 1'b0;
  logic        halted;
`ifdef IFU_BRANCH_COUNT_EN
  logic [15:0] branch_count;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [20:0] exp_pc = '0;
  logic [31:0] prev_instr = '0;
  int          exp_bc = 0;

  instr_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_control  (pc_control),
    .jump_target (jump_target),
    .zero_flag   (zero_flag),
    .below_flag  (below_flag),
    .halt        (halt),
    .exec_done   (exec_done),
`ifdef IFU_BRANCH_COUNT_EN
    .branch_count(branch_count),
`endif
    .halted      (halted)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Branch condition straight from the instruction-set definition.
  function automatic bit ref_taken(input int op, input bit z, input bit b);
    if (op == 0) return 0;
    if (op == 1) return 1;
    if (op == 2) return z;
    if (op == 3) return !z;
    if (op == 4) return b;
    if (op == 5) return !b && !z;
    if (op == 6) return b || z;
    return !b;
  endfunction

  task automatic drive_junk();
    pc_control  = 3'($urandom_range(0, 7));
    jump_target = 21'($urandom);
    zero_flag   = 1'($urandom_range(0, 1));
    below_flag  = 1'($urandom_range(0, 1));
    halt        = 1'($urandom_range(0, 1));
  endtask

  // Serves one instruction as memory and control unit; checks every phase against the model.
  task automatic run_instr(input int rdly, input int edly, input int pcc, input bit zf, input bit bf,
                           input logic [20:0] tgt, input bit hlt, input bit chk_timing);
    int          t0;
    int          guard;
    logic [31:0] word;
    logic [20:0] nxt;
    bit          tk;
    mem_ready = 1'b0;
    exec_done = 1'($urandom_range(0, 1));
    drive_junk();
    guard = 0;
    while (mem_req !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_bad++;
      $display("FAIL fetch_timeout: mem_req=%b after %0d cycles, required 1", mem_req, guard);
      return;
    end
    t0 = cyc;
    n_cmp++;
    if (mem_addr !== exp_pc || pc !== exp_pc) begin
      n_bad++;
      $display("FAIL fetch_addr: mem_addr=%h pc=%h, required %h", mem_addr, pc, exp_pc);
    end
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_valid: instr_valid=%b, required 0", instr_valid);
    end
    repeat (rdly) begin
      mem_ready = 1'b0;
      exec_done = 1'($urandom_range(0, 1));
      drive_junk();
      @(negedge clock);
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== exp_pc || instruction !== prev_instr) begin
        n_bad++;
        $display("FAIL fetch_wait: req=%b addr=%h instr=%h, required 1 %h %h",
                 mem_req, mem_addr, instruction, exp_pc, prev_instr);
      end
    end
    word      = $urandom;
    mem_data  = word;
    mem_ready = 1'b1;
    exec_done = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (instruction !== word || instr_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL issue_entry: instr=%h valid=%b req=%b, required %h 1 0",
               instruction, instr_valid, mem_req, word);
    end
    prev_instr = word;
    repeat (edly) begin
      mem_data  = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      exec_done = 1'b0;
      drive_junk();
      @(negedge clock);
      n_cmp++;
      if (instruction !== word || instr_valid !== 1'b1 || mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL issue_hold: instr=%h valid=%b req=%b, required %h 1 0",
                 instruction, instr_valid, mem_req, word);
      end
    end
    mem_data    = $urandom;
    mem_ready   = 1'($urandom_range(0, 1));
    exec_done   = 1'b1;
    pc_control  = 3'(pcc);
    zero_flag   = zf;
    below_flag  = bf;
    jump_target = tgt;
    halt        = hlt;
    @(negedge clock);
    exec_done = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    tk  = ref_taken(pcc, zf, bf);
    nxt = hlt ? exp_pc : (tk ? tgt : exp_pc + 21'd1);
    if (!hlt && tk && pcc != 0 && exp_bc < 65535) exp_bc++;
    n_cmp++;
    if (pc !== nxt || halted !== hlt || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL update: pc=%h halted=%b valid=%b, required %h %b 0 (op=%0d z=%0d b=%0d)",
               pc, halted, instr_valid, nxt, hlt, pcc, zf, bf);
    end
    n_cmp++;
    if (mem_req !== !hlt) begin
      n_bad++;
      $display("FAIL update_req: mem_req=%b, required %b", mem_req, !hlt);
    end
    if (chk_timing) begin
      n_cmp++;
      if (cyc - t0 !== 3 + rdly + edly) begin
        n_bad++;
        $display("FAIL loop_cycles: %0d cycles, required %0d", cyc - t0, 3 + rdly + edly);
      end
    end
`ifdef IFU_BRANCH_COUNT_EN
    n_cmp++;
    if (branch_count !== 16'(exp_bc)) begin
      n_bad++;
      $display("FAIL branch_count: %0d, required %0d", branch_count, exp_bc);
    end
`endif
    exp_pc = nxt;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    exec_done = 1'b1;
    drive_junk();
    repeat (2) @(negedge clock);
    n_cmp++;
    if (pc !== 21'd0 || instruction !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_regs: pc=%h instr=%h, required 0 0", pc, instruction);
    end
    n_cmp++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: valid=%b req=%b halted=%b, required 0 0 0",
               instr_valid, mem_req, halted);
    end
    exp_pc     = '0;
    prev_instr = '0;
    exp_bc     = 0;
    mem_ready  = 1'b0;
    reset      = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 21'($urandom), 0, 1);
    n_cmp++;
    if (exp_pc !== 21'd3 || pc !== 21'd3) begin
      n_bad++;
      $display("FAIL seq_pc: pc=%h, required 3", pc);
    end
  endtask

  task automatic test_cond_branch();
    run_instr(0, 0, 1, 0, 0, 21'd5, 0, 1);
    run_instr(0, 0, 2, 1, 0, 21'd40, 0, 1);
    run_instr(1, 0, 1, 0, 0, 21'd5, 0, 1);
    run_instr(0, 1, 2, 0, 0, 21'd40, 0, 1);
  endtask

  task automatic test_ja_jbe();
    run_instr(0, 0, 5, 0, 0, 21'h00100, 0, 1);
    run_instr(0, 0, 5, 1, 0, 21'h00200, 0, 1);
    run_instr(0, 0, 6, 0, 1, 21'h00300, 0, 1);
    run_instr(0, 0, 7, 0, 1, 21'h00400, 0, 1);
    run_instr(0, 0, 3, 0, 0, 21'h00500, 0, 1);
    run_instr(0, 0, 4, 1, 0, 21'h00600, 0, 1);
  endtask

  task automatic test_stalls();
    run_instr(4, 0, 0, 0, 0, 21'd0, 0, 1);
    run_instr(0, 10, 0, 0, 0, 21'd0, 0, 1);
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 1, 0, 0, 21'h1FFFFF, 0, 1);
    run_instr(0, 0, 0, 0, 0, 21'h012345, 0, 1);
    n_cmp++;
    if (pc !== 21'd0) begin
      n_bad++;
      $display("FAIL pc_wrap: pc=%h, required 0", pc);
    end
  endtask

  task automatic test_branch_count();
    test_reset();
    run_instr(0, 0, 1, 0, 0, 21'd10, 0, 0);
    run_instr(0, 0, 2, 1, 0, 21'd20, 0, 1);
    run_instr(0, 0, 2, 0, 0, 21'd99, 0, 1);
    run_instr(0, 0, 0, 0, 0, 21'd99, 0, 1);
    run_instr(0, 0, 7, 0, 0, 21'd30, 0, 1);
    n_cmp++;
    if (exp_pc !== 21'd30) begin
      n_bad++;
      $display("FAIL taken_path: model pc=%h, required 1e", exp_pc);
    end
`ifdef IFU_BRANCH_COUNT_EN
    n_cmp++;
    if (branch_count !== 16'd3) begin
      n_bad++;
      $display("FAIL branch_count_3: %0d, required 3", branch_count);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 21'($urandom), 0, 1);
  endtask

  task automatic test_reset_mid_fetch();
    int guard;
    mem_ready = 1'b0;
    guard = 0;
    while (mem_req !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (mem_req !== 1'b0 || pc !== 21'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_fetch_reset: req=%b pc=%h valid=%b halted=%b, required 0 0 0 0",
               mem_req, pc, instr_valid, halted);
    end
    mem_ready = 1'b1;
    mem_data  = 32'hDEADBEEF;
    @(negedge clock);
    n_cmp++;
    if (instruction !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_ignores_ready: instr=%h, required 0", instruction);
    end
    mem_ready  = 1'b0;
    reset      = 1'b1;
    exp_pc     = '0;
    prev_instr = '0;
    exp_bc     = 0;
    run_instr(0, 0, 0, 0, 0, 21'd7, 0, 0);
  endtask

  task automatic test_halt();
    run_instr(0, 0, 1, 0, 0, 21'h0ABCD, 1, 1);
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      drive_junk();
      @(negedge clock);
      n_cmp++;
      if (mem_req !== 1'b0 || halted !== 1'b1 || pc !== exp_pc || instr_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL halt_hold: req=%b halted=%b pc=%h valid=%b, required 0 1 %h 0",
                 mem_req, halted, pc, instr_valid, exp_pc);
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_sequential();
    test_cond_branch();
    test_ja_jbe();
    test_stalls();
    test_wrap();
    test_branch_count();
    test_random();
    test_reset_mid_fetch();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the control unit and owns the program counter.
- Reads 32-bit instruction words from instruction memory over a req/ready handshake, then holds the word in an instruction register that drives the control unit.
- After the datapath signals completion, computes the next PC from the control unit's pcControl, jump target and ALU flags.
- Stops at HLT.

Parameters:
- ADDR_W, 21, PC/jump-target width; matches the op2 field width.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_W, 32, instruction word width.

Ports:
- clock  in  1  rising-edge system clock
- reset  in  1  synchronous, active-low reset
- mem_req  out  1  instruction memory read request
- mem_addr  out  ADDR_W  read address (equals pc)
- mem_ready  in  1  memory data valid this cycle
- mem_data  in  INSTR_W  instruction word from memory
- instruction  out  INSTR_W  instruction register, drives the control unit
- instr_valid  out  1  instruction register holds a live instruction
- pc  out  ADDR_W  address of the current instruction
- pc_control  in  3  from control unit: 0 seq, 1 JMP, 2 JE/JZ, 3 JNE/JNZ, 4 JB, 5 JA, 6 JBE, 7 JAE
- jump_target  in  ADDR_W  from control unit op2
- zero_flag  in  1  ALU result zero/equal
- below_flag  in  1  ALU borrow/below
- halt  in  1  decoded HLT
- exec_done  in  1  datapath finished the current instruction (allows multicycle DIV/MUL)
- halted  out  1  unit stopped

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc=RESET_PC, instruction=0, instr_valid=0, mem_req=0, halted=0, state=FETCH.
  - Overrides any in-flight fetch; mem_req is low the cycle after reset is sampled.
- FSM states: FETCH, ISSUE, UPDATE, HALT.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_ready=1: instruction<=mem_data, instr_valid<=1, go to ISSUE.
  - Otherwise hold; mem_addr stays stable while waiting.
- ISSUE:
  - mem_req=0; instruction is held stable.
  - On exec_done=1 go to UPDATE (exec_done in the same cycle as entry is allowed, giving a 1-cycle ISSUE).
- UPDATE:
  - Samples pc_control, jump_target, the flags and halt in a single cycle.
  - instr_valid<=0.
  - halt=1: go to HALT, pc unchanged (points at the HLT). halt has priority over any jump.
  - Otherwise taken is computed as:
    - 0 -> 0
    - 1 -> 1
    - 2 -> zero
    - 3 -> !zero
    - 4 -> below
    - 5 -> !below && !zero
    - 6 -> below || zero
    - 7 -> !below
  - pc<=taken ? jump_target : pc+1, then go to FETCH.
- HALT: halted=1, mem_req=0, instr_valid=0; stays until reset.
- Arithmetic and timing:
  - pc+1 wraps modulo 2^ADDR_W (max address -> 0).
  - Minimum loop is 3 cycles per instruction: FETCH with ready the same cycle, ISSUE with exec_done the same cycle, then UPDATE.
- Ignored inputs:
  - mem_ready outside FETCH.
  - exec_done outside ISSUE.
  - Flags and pc_control outside UPDATE.

Optional Feature:
- Macro: IFU_BRANCH_COUNT_EN.
- Defined:
  - Adds output branch_count[15:0], reset to 0.
  - Increments in UPDATE when taken=1 and pc_control!=0 and halt=0.
  - Saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - pc_control encodings (PC_SEQ..PC_JAE), matching the control unit's outputs.
  - FSM state typedef.
  - ADDR_W/INSTR_W defaults.
- One natural sub-module: branch_resolve. Combinational function of pc_control and the flags that produces taken; reusable by the verification model.

Test Plan:
- Reset, then memory returns ADD at 0, exec_done immediate, pc_control=0 -> fetch addresses 0,1,2 in turn; instr_valid pulses once per instruction; 3 cycles per instruction.
- pc=5, pc_control=2, zero_flag=1, jump_target=40 -> next mem_addr=40. Repeat with zero_flag=0 -> next mem_addr=6.
- pc_control=5 with below=0 and zero=0 -> taken; with zero=1 -> not taken. pc_control=6 with below=1 -> taken.
- mem_ready delayed 4 cycles -> mem_req and mem_addr stable throughout, instruction updates only on the ready cycle. exec_done delayed 10 cycles -> instruction held stable.
- pc=2^21-1, pc_control=0 -> next pc=0. halt=1 together with pc_control=1 -> halted=1, pc unchanged, no further mem_req.
- reset=0 asserted mid-FETCH while mem_ready is still pending -> mem_req low next cycle, pc=RESET_PC. With IFU_BRANCH_COUNT_EN defined, 3 taken jumps -> branch_count=3.
